// File: rtl/adc_scan_sched.sv
// adc_scan_sched: periodic two-channel ADC scan scheduler.
// Requests a conversion on ch1 then ch2, latches the top byte of each sample,
// raises sticky over-range/timeout flags and a level interrupt, and exposes
// CTRL / PERIOD / STATUS / SAMPLES through a small Avalon-MM slave.
module adc_scan_sched #(
    parameter int ADC_W    = 12,
    parameter int PERIOD_W = 16,
    parameter int TIMEOUT  = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       range1,
    input  logic [7:0]       range2,
    output logic             adc_req,
    output logic             adc_ch,
    input  logic             adc_valid,
    input  logic [ADC_W-1:0] adc_data,
    input  logic [1:0]       address,
    input  logic             read,
    output logic [15:0]      readdata,
    input  logic             write,
    input  logic [15:0]      writedata,
    output logic             irq
);

    localparam int TO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_WAIT_TICK = 3'd1;
    localparam logic [2:0] S_REQ1      = 3'd2;
    localparam logic [2:0] S_WAIT1     = 3'd3;
    localparam logic [2:0] S_REQ2      = 3'd4;
    localparam logic [2:0] S_WAIT2     = 3'd5;
    localparam logic [2:0] S_DONE      = 3'd6;

    logic [2:0]          state_reg, state_next;
    logic [PERIOD_W-1:0] period_cnt_reg, period_cnt_next;
    logic [TO_W-1:0]     to_cnt_reg, to_cnt_next;
    logic [1:0]          ctrl_reg;
    logic [PERIOD_W-1:0] period_reg;
    logic [2:0]          status_reg, status_next;
    logic [15:0]         readdata_reg, rd_mux;
    logic                irq_reg;

    logic       enable;
    logic       wait_state;
    logic       got_valid;
    logic       timed_out;
    logic [7:0] adc_top8;
    logic [2:0] w1c_mask;
    logic [1:0] ch_over;
    logic       unused_adc;

    assign enable     = ctrl_reg[0];
    assign adc_top8   = adc_data[ADC_W-1 -: 8];
    assign unused_adc = ^adc_data;
    assign wait_state = (state_reg == S_WAIT1) || (state_reg == S_WAIT2);
    assign got_valid  = wait_state && adc_valid;
    // A valid arriving on the last allowed cycle still counts as a response.
    assign timed_out  = wait_state && !adc_valid && (to_cnt_reg == TO_W'(TIMEOUT));

    // Per-channel sample latch and over-range detection; each channel only
    // listens while the FSM waits on it, so stray valids are ignored.
    for (genvar gi = 0; gi < 2; gi++) begin : ch_g
        logic       hit;
        logic [7:0] thr;
        logic [7:0] sample_reg;

        assign hit         = got_valid && (state_reg == ((gi == 0) ? S_WAIT1 : S_WAIT2));
        assign thr         = (gi == 0) ? range1 : range2;
        assign ch_over[gi] = hit && (adc_top8 > thr);

        // Latch the top byte of the response; a timeout keeps the old value.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                sample_reg <= 8'd0;
            end else if (hit) begin
                sample_reg <= adc_top8;
            end
        end
    end

    // Scan sequencing: tick wait, then ch1 and ch2 request/response pairs.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (enable) state_next = S_WAIT_TICK;
            end
            S_WAIT_TICK: begin
                if (!enable)
                    state_next = S_IDLE;
                else if (period_cnt_reg >= period_reg)
                    state_next = S_REQ1;
            end
            S_REQ1: state_next = S_WAIT1;
            S_WAIT1: begin
                // Losing enable skips ch2 but never abandons the ch1 request.
                if (got_valid || timed_out)
                    state_next = enable ? S_REQ2 : S_IDLE;
            end
            S_REQ2: state_next = S_WAIT2;
            S_WAIT2: begin
                if (got_valid || timed_out) state_next = S_DONE;
            end
            S_DONE: state_next = enable ? S_WAIT_TICK : S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Counters run only while staying in their state and restart on entry.
    always_comb begin
        period_cnt_next = '0;
        to_cnt_next     = '0;
        if (state_reg == S_WAIT_TICK && state_next == S_WAIT_TICK)
            period_cnt_next = period_cnt_reg + 1'b1;
        if (wait_state && state_next == state_reg)
            to_cnt_next = to_cnt_reg + 1'b1;
    end

    // Sticky flags: a new event wins over a same-cycle write-1-to-clear.
    always_comb begin
        w1c_mask    = (write && address == 2'd2) ? writedata[2:0] : 3'b000;
        status_next = (status_reg & ~w1c_mask) | {timed_out, ch_over[1], ch_over[0]};
    end

    // Register read multiplexer.
    always_comb begin
        rd_mux = 16'd0;
        case (address)
            2'd0: rd_mux = {14'd0, ctrl_reg};
            2'd1: rd_mux = 16'(period_reg);
            2'd2: rd_mux = {13'd0, status_reg};
            2'd3: rd_mux = {ch_g[1].sample_reg, ch_g[0].sample_reg};
            default: rd_mux = 16'd0;
        endcase
    end

    // State, counters, registers, read data and interrupt.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= S_IDLE;
            period_cnt_reg <= '0;
            to_cnt_reg     <= '0;
            ctrl_reg       <= 2'b00;
            period_reg     <= '0;
            status_reg     <= 3'b000;
            readdata_reg   <= 16'd0;
            irq_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            period_cnt_reg <= period_cnt_next;
            to_cnt_reg     <= to_cnt_next;
            status_reg     <= status_next;
            irq_reg        <= ctrl_reg[1] && (status_reg != 3'b000);
            if (write && address == 2'd0) ctrl_reg <= writedata[1:0];
            if (write && address == 2'd1) period_reg <= PERIOD_W'(writedata);
            if (read) readdata_reg <= rd_mux;
        end
    end

    assign adc_req  = (state_reg == S_REQ1) || (state_reg == S_REQ2);
    assign adc_ch   = (state_reg == S_REQ2) || (state_reg == S_WAIT2);
    assign readdata = readdata_reg;
    assign irq      = irq_reg;

endmodule

// File: tb/tb_adc_scan_sched.sv
// Directed bench for adc_scan_sched: reset, scan timing, threshold compare,
// W1C behaviour, timeout, enable drop mid-scan and asynchronous reset.
module tb_adc_scan_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  range1, range2;
    logic        adc_req, adc_ch;
    logic        adc_valid;
    logic [11:0] adc_data;
    logic [1:0]  address;
    logic        read, write;
    logic [15:0] readdata, writedata;
    logic        irq;

    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;
    int r1, r2, k, nreq;
    logic [15:0] rd;

    adc_scan_sched #(.ADC_W(12), .PERIOD_W(16), .TIMEOUT(255)) dut (
        .clk(clk), .reset(reset), .range1(range1), .range2(range2),
        .adc_req(adc_req), .adc_ch(adc_ch), .adc_valid(adc_valid),
        .adc_data(adc_data), .address(address), .read(read),
        .readdata(readdata), .write(write), .writedata(writedata), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic reg_write(input logic [1:0] a, input logic [15:0] d);
        address = a; writedata = d; write = 1'b1;
        step();
        write = 1'b0;
    endtask

    task automatic reg_read(input logic [1:0] a, output logic [15:0] d);
        address = a; read = 1'b1;
        step();
        read = 1'b0;
        d = readdata;
    endtask

    // Poll for a request pulse with a bounded cycle budget.
    task automatic wait_req(output int at);
        int n = 0;
        while (adc_req !== 1'b1 && n < 300) begin
            step();
            n++;
        end
        at = cyc;
        chk("req_seen", {31'd0, adc_req}, 32'd1);
    endtask

    // Answer the next request lat cycles after it with sample d.
    task automatic serve(input int lat, input logic [11:0] d, input logic ch, output int at);
        wait_req(at);
        chk("req_ch", {31'd0, adc_ch}, {31'd0, ch});
        step();
        chk("req_one_cycle", {31'd0, adc_req}, 32'd0);
        for (int i = 1; i < lat; i++) step();
        chk("ch_held", {31'd0, adc_ch}, {31'd0, ch});
        adc_valid = 1'b1; adc_data = d;
        step();
        adc_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; range1 = 8'h80; range2 = 8'h80;
        adc_valid = 1'b0; adc_data = 12'h000;
        address = 2'd0; read = 1'b0; write = 1'b0; writedata = 16'h0000;
        step(); step();
        reset = 1'b0;

        // Reset state.
        chk("rst_adc_req", {31'd0, adc_req}, 32'd0);
        chk("rst_adc_ch", {31'd0, adc_ch}, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        chk("rst_readdata", {16'd0, readdata}, 32'd0);
        reg_read(2'd0, rd); chk("rst_ctrl", {16'd0, rd}, 32'd0);
        reg_read(2'd1, rd); chk("rst_period", {16'd0, rd}, 32'd0);
        reg_read(2'd2, rd); chk("rst_status", {16'd0, rd}, 32'd0);
        reg_read(2'd3, rd); chk("rst_samples", {16'd0, rd}, 32'd0);

        // Scan 1: PERIOD=3, enable+irq_en, equal/below threshold -> no flags.
        reg_write(2'd1, 16'd3);
        reg_write(2'd0, 16'h0003);
        reg_read(2'd1, rd); chk("period_rb", {16'd0, rd}, 32'd3);
        serve(2, 12'h800, 1'b0, r1);
        serve(2, 12'h7F0, 1'b1, k);
        chk("scan1_irq", {31'd0, irq}, 32'd0);
        reg_read(2'd2, rd); chk("scan1_status", {16'd0, rd}, 32'd0);
        reg_read(2'd3, rd); chk("scan1_samples", {16'd0, rd}, 32'h7F80);

        // Scan 2: start spacing = tick(4) + REQ1 + WAIT1(2) + REQ2 + WAIT2(2) + DONE = 11.
        serve(2, 12'h810, 1'b0, r2);
        chk("scan_spacing", r2 - r1, 32'd11);
        chk("irq_latency", {31'd0, irq}, 32'd0);
        serve(2, 12'h7F0, 1'b1, k);
        chk("irq_set", {31'd0, irq}, 32'd1);
        reg_read(2'd2, rd); chk("ch1_over", {16'd0, rd}, 32'h1);
        reg_write(2'd2, 16'h0001);
        chk("irq_lag_clear", {31'd0, irq}, 32'd1);
        step();
        chk("irq_clear", {31'd0, irq}, 32'd0);
        reg_read(2'd2, rd); chk("w1c_ch1", {16'd0, rd}, 32'h0);

        // Scan 3: ch2 never answers -> timeout after 256 wait cycles.
        serve(2, 12'h700, 1'b0, k);
        wait_req(k);
        chk("to_req_ch", {31'd0, adc_ch}, 32'd1);
        for (int i = 0; i < 256; i++) step();
        step();
        chk("to_irq_pre", {31'd0, irq}, 32'd0);
        step();
        chk("to_irq", {31'd0, irq}, 32'd1);
        reg_read(2'd2, rd); chk("to_status", {16'd0, rd}, 32'h4);
        reg_read(2'd3, rd); chk("to_samples", {16'd0, rd}, 32'h7F70);
        reg_write(2'd2, 16'h0004);

        // Scan 4: W1C of bit1 on the cycle a ch2 over-range sample lands.
        serve(1, 12'h700, 1'b0, k);
        wait_req(k);
        step();
        adc_valid = 1'b1; adc_data = 12'h900;
        address = 2'd2; writedata = 16'h0002; write = 1'b1;
        step();
        adc_valid = 1'b0; write = 1'b0;
        reg_read(2'd2, rd); chk("set_beats_clr", {16'd0, rd}, 32'h2);
        reg_write(2'd2, 16'h0002);
        reg_read(2'd2, rd); chk("w1c_ch2", {16'd0, rd}, 32'h0);

        // Scan 5: drop enable during WAIT1.
        wait_req(k);
        chk("s5_ch", {31'd0, adc_ch}, 32'd0);
        reg_write(2'd0, 16'h0002);
        adc_valid = 1'b1; adc_data = 12'hA50;
        step();
        adc_valid = 1'b0;
        nreq = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (adc_req === 1'b1) nreq++;
        end
        chk("no_ch2_req", nreq, 32'd0);
        reg_read(2'd3, rd); chk("s5_samples", {16'd0, rd}, 32'h90A5);
        reg_read(2'd2, rd); chk("s5_status", {16'd0, rd}, 32'h1);
        chk("s5_irq", {31'd0, irq}, 32'd1);
        adc_valid = 1'b1; adc_data = 12'hFF0;
        step();
        adc_valid = 1'b0;
        reg_read(2'd3, rd); chk("stray_samples", {16'd0, rd}, 32'h90A5);
        reg_read(2'd2, rd); chk("stray_status", {16'd0, rd}, 32'h1);

        // Asynchronous reset in the middle of WAIT1.
        reg_write(2'd1, 16'd0);
        reg_write(2'd0, 16'h0003);
        wait_req(k);
        step();
        #2;
        reset = 1'b1;
        #1;
        chk("arst_adc_req", {31'd0, adc_req}, 32'd0);
        chk("arst_adc_ch", {31'd0, adc_ch}, 32'd0);
        chk("arst_irq", {31'd0, irq}, 32'd0);
        chk("arst_readdata", {16'd0, readdata}, 32'd0);
        step();
        reset = 1'b0;
        reg_read(2'd0, rd); chk("arst_ctrl", {16'd0, rd}, 32'd0);
        reg_read(2'd1, rd); chk("arst_period", {16'd0, rd}, 32'd0);
        reg_read(2'd2, rd); chk("arst_status", {16'd0, rd}, 32'd0);
        reg_read(2'd3, rd); chk("arst_samples", {16'd0, rd}, 32'd0);
        nreq = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (adc_req === 1'b1) nreq++;
        end
        chk("arst_no_req", nreq, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
